poly_synth_pwm: RTL and testbench
=================================

Name: poly_synth_pwm

Overview:
Parametrised polyphonic square-wave synthesiser core. It has NVOICES independent tone generators with runtime-programmable pitch, a global octave shift, and per-voice attack/release envelopes. Voice outputs are summed by an amplitude mixer and drive a frame-latched PWM DAC. It is the next-generation replacement for the fixed-table single-envelope synth core behind the TinyTapeout top.

Parameters:
NVOICES, 5, number of voices (>=1)
DIV_W, 16, half-period register/counter width
AMP_W, 4, envelope amplitude width; AMP_MAX = 2^AMP_W-1
PWM_W, 8, PWM counter and mix width; must satisfy 2^PWM_W-1 >= NVOICES*AMP_MAX
ENV_DIV_W, 12, envelope prescaler width

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
note_en  in  NVOICES  per-voice gate, active high
cfg_we  in  1  half-period write strobe
cfg_addr  in  max(1,clog2(NVOICES))  voice index for write
cfg_data  in  DIV_W  half-period value (in clk cycles)
octave  in  2  global pitch shift, divides half-period by 2^octave
env_mode  in  1  0 = gate (instant), 1 = ramp envelope
env_rate  in  ENV_DIV_W  envelope tick divisor
pwm_out  out  1  PWM audio output
mix_out  out  PWM_W  registered mixer sum (observability)
active  out  NVOICES  per-voice amp != 0

Behaviour:
- Reset (async, rst_n=0): hp[], cnt[], wave[], amp[], prescaler, mix_out, mix_latched, pwm_cnt, pwm_out all 0 immediately. active=0. Reset mid-note silences on assertion; there is no release tail.
- Config: at rising clk with cfg_we=1 and cfg_addr<NVOICES, hp[cfg_addr] <= cfg_data. cfg_addr>=NVOICES: write dropped. cnt and wave are not disturbed.
- Tone per voice: ehp = hp >> octave (combinational).
  - ehp==0: cnt<=0, wave<=0. The voice is muted.
  - Otherwise, if cnt >= ehp-1: cnt<=0 and wave toggles; else cnt<=cnt+1.
  - Wave period is 2*ehp cycles. The >= compare guarantees a wrap on the next cycle when hp or octave shrinks below cnt; there is no lockup.
- Envelope prescaler: pre counts 0..env_rate. tick=1 for one cycle when pre==env_rate, then pre<=0. env_rate=0 gives a tick every cycle. If env_rate is lowered below pre, the >= compare applies.
- env_mode=0: each cycle, amp <= note_en ? AMP_MAX : 0. Latency is 1 cycle from note_en.
- env_mode=1: on tick only.
  - note_en=1 and amp<AMP_MAX: amp+1.
  - note_en=0 and amp>0: amp-1.
  - Otherwise amp holds. Saturates at both ends.
  - A gate change mid-ramp reverses direction from the current amp.
- Mode switch 1->0 takes effect on the next cycle. Switch 0->1 continues ramping from the current amp.
- active[i] = (amp[i]!=0), driven directly from the register.
- Mixer: mix_out <= sum over i of (wave[i] ? amp[i] : 0), zero-extended to PWM_W. Latency is 1 cycle after wave/amp. Overflow is impossible by the parameter rule.
- PWM: pwm_cnt is free-running 0..2^PWM_W-1 and wraps.
  - When pwm_cnt==2^PWM_W-1: mix_latched <= mix_out (frame boundary only, glitch-free).
  - Each cycle: pwm_out <= (pwm_cnt < mix_latched).
  - Duty is mix_latched/2^PWM_W. mix_latched=0 gives constant 0.
- All inputs are synchronous to clk. Upstream is responsible for synchronising external pins.

Test Plan:
1. Reset/idle: pulse rst_n low mid-run, then release with no cfg writes, note_en=all 1 -> all outputs 0 during reset; pwm_out=0, mix_out=0 for 2000 cycles (hp=0 mutes). active becomes all 1 one cycle after release with env_mode=0.
2. Basic tone: cfg write hp[0]=4, octave=0, env_mode=0, note_en=00001 -> wave0 toggles every 4 cycles; mix_out alternates 0/15 with 4-cycle runs; after frame latch, pwm_out high 15 of 256 cycles during a high-mix frame.
3. Octave/shrink: hp[1]=16, octave=2 -> half-period 4. Then hp[1]=1000, let cnt reach ~500, write hp[1]=2 -> cnt wraps next cycle; half-period 2 thereafter. cfg_addr=7 write -> no hp change.
4. Envelope ramp: env_mode=1, env_rate=3, note_en[2] 0->1 -> amp rises by 1 every 4 cycles, reaching 15 after 60 cycles. Drop gate at amp=9 -> decays to 0 in 36 cycles; active[2] falls with amp=0.
5. Full polyphony: all 5 voices hp=8, simultaneous write sequence aligning waves, env_mode=0, all gates on -> mix_out peaks at 75; pwm_out high exactly 75 cycles in a latched frame of 256.
6. Frame latch: change mix mid-frame -> pwm_out duty changes only from the frame after the next pwm_cnt==255.

Source files
------------

// File: rtl/poly_synth_pwm.sv
// -----------------------------------------------------------------------------
// poly_synth_pwm
//
// Polyphonic square-wave synthesiser core with a PWM DAC back end.
//
// Each of NVOICES voices has a runtime-programmable half-period (in clock
// cycles). A global octave shift divides every half-period by 2^octave. Each
// voice carries an amplitude envelope that either follows its gate instantly
// (gate mode) or ramps one step per prescaler tick (ramp mode). The voices are
// summed by an amplitude mixer. The mixer feeds a PWM DAC whose duty value is
// latched only at frame boundaries, so a frame is never cut short.
//
// Ports:
//   i_clk        system clock, every register updates on the rising edge
//   i_rst_n      asynchronous active-low reset, clears all state at once
//   i_note_en    per-voice gate, active high
//   i_cfg_we     half-period write strobe
//   i_cfg_addr   voice index for the write; indices >= NVOICES are ignored
//   i_cfg_data   half-period value in clock cycles (0 mutes the voice)
//   i_octave     global pitch shift, divides the half-period by 2^octave
//   i_env_mode   0 = gate (instant amplitude), 1 = ramped envelope
//   i_env_rate   envelope prescaler divisor (one tick every env_rate+1 cycles)
//   o_pwm_out    PWM audio output
//   o_mix_out    registered mixer sum, exposed for observability
//   o_active     per-voice flag, high while the voice amplitude is non-zero
//
// All inputs must already be synchronous to i_clk.
// -----------------------------------------------------------------------------
module poly_synth_pwm #(
    parameter int NVOICES   = 5,
    parameter int DIV_W     = 16,
    parameter int AMP_W     = 4,
    parameter int PWM_W     = 8,
    parameter int ENV_DIV_W = 12,
    localparam int ADDR_W   = (NVOICES > 1) ? $clog2(NVOICES) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [NVOICES-1:0]   i_note_en,
    input  logic                 i_cfg_we,
    input  logic [ADDR_W-1:0]    i_cfg_addr,
    input  logic [DIV_W-1:0]     i_cfg_data,
    input  logic [1:0]           i_octave,
    input  logic                 i_env_mode,
    input  logic [ENV_DIV_W-1:0] i_env_rate,
    output logic                 o_pwm_out,
    output logic [PWM_W-1:0]     o_mix_out,
    output logic [NVOICES-1:0]   o_active
);

    localparam logic [AMP_W-1:0] AMP_MAX = '1;

    // -------------------------------------------------------------------------
    // Per-voice state
    // -------------------------------------------------------------------------
    logic [DIV_W-1:0] r_hp   [NVOICES];
    logic [DIV_W-1:0] r_cnt  [NVOICES];
    logic             r_wave [NVOICES];
    logic [AMP_W-1:0] r_amp  [NVOICES];

    // -------------------------------------------------------------------------
    // Envelope prescaler
    // -------------------------------------------------------------------------
    logic [ENV_DIV_W-1:0] r_pre;
    logic                 w_tick;

    // ">=" rather than "==" so that lowering env_rate below the current count
    // produces a tick on the very next cycle instead of a long wrap-around.
    assign w_tick = (r_pre >= i_env_rate);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pre <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + ENV_DIV_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Voices: half-period register, tone counter and envelope
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < NVOICES; gi++) begin : g_voice
        logic [DIV_W-1:0] w_ehp;
        logic             w_hp_wr;
        logic             w_wrap;

        assign w_ehp = r_hp[gi] >> i_octave;

        // Only addresses below NVOICES can match a voice index, so writes to
        // out-of-range addresses fall through without touching any voice.
        assign w_hp_wr = i_cfg_we && (i_cfg_addr == ADDR_W'(gi));

        // ">=" compare: if the half-period shrinks below the running count
        // (new hp or larger octave), the counter wraps on the next cycle.
        assign w_wrap = (r_cnt[gi] >= (w_ehp - DIV_W'(1)));

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_hp[gi] <= '0;
            end else if (w_hp_wr) begin
                r_hp[gi] <= i_cfg_data;
            end
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_cnt[gi]  <= '0;
                r_wave[gi] <= 1'b0;
            end else if (w_ehp == '0) begin
                // Zero effective half-period mutes the voice and parks it at
                // a known phase.
                r_cnt[gi]  <= '0;
                r_wave[gi] <= 1'b0;
            end else if (w_wrap) begin
                r_cnt[gi]  <= '0;
                r_wave[gi] <= ~r_wave[gi];
            end else begin
                r_cnt[gi]  <= r_cnt[gi] + DIV_W'(1);
            end
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_amp[gi] <= '0;
            end else if (!i_env_mode) begin
                r_amp[gi] <= i_note_en[gi] ? AMP_MAX : '0;
            end else if (w_tick) begin
                // Direction follows the current gate, so a gate change in the
                // middle of a ramp simply reverses from the present level.
                if (i_note_en[gi] && (r_amp[gi] != AMP_MAX)) begin
                    r_amp[gi] <= r_amp[gi] + AMP_W'(1);
                end else if (!i_note_en[gi] && (r_amp[gi] != '0)) begin
                    r_amp[gi] <= r_amp[gi] - AMP_W'(1);
                end
            end
        end

        assign o_active[gi] = (r_amp[gi] != '0);
    end

    // -------------------------------------------------------------------------
    // Mixer: sum of the amplitudes of all voices whose square wave is high.
    // PWM_W is sized so that the full sum cannot overflow.
    // -------------------------------------------------------------------------
    logic [PWM_W-1:0] w_mix_sum;
    logic [PWM_W-1:0] r_mix;

    always_comb begin
        w_mix_sum = '0;
        for (int i = 0; i < NVOICES; i++) begin
            if (r_wave[i]) begin
                w_mix_sum = w_mix_sum + PWM_W'(r_amp[i]);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mix <= '0;
        end else begin
            r_mix <= w_mix_sum;
        end
    end

    assign o_mix_out = r_mix;

    // -------------------------------------------------------------------------
    // PWM DAC
    // -------------------------------------------------------------------------
    logic [PWM_W-1:0] r_pwm_cnt;
    logic [PWM_W-1:0] r_mix_latched;
    logic             r_pwm;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pwm_cnt     <= '0;
            r_mix_latched <= '0;
            r_pwm         <= 1'b0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
            // Duty value only changes on the last count of a frame, so the
            // next frame is generated entirely from one value.
            if (&r_pwm_cnt) begin
                r_mix_latched <= r_mix;
            end
            r_pwm <= (r_pwm_cnt < r_mix_latched);
        end
    end

    assign o_pwm_out = r_pwm;

endmodule

// File: tb/tb_poly_synth_pwm.sv
// -----------------------------------------------------------------------------
// tb_poly_synth_pwm
//
// Self-checking bench for poly_synth_pwm. A behavioural reference model kept
// in plain integers is advanced once per clock and its outputs are compared
// with the design after every edge. Directed checks cover the reset state,
// mixer peaks and whole-frame PWM duty.
// -----------------------------------------------------------------------------
module tb_poly_synth_pwm;

    localparam int NV        = 5;
    localparam int DIV_W     = 16;
    localparam int AMP_W     = 4;
    localparam int PWM_W     = 8;
    localparam int ENV_DIV_W = 12;
    localparam int ADDR_W    = 3;
    localparam int AMP_MAX   = 15;
    localparam int PWM_MOD   = 256;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NV-1:0]        note_en;
    logic                 cfg_we;
    logic [ADDR_W-1:0]    cfg_addr;
    logic [DIV_W-1:0]     cfg_data;
    logic [1:0]           octave;
    logic                 env_mode;
    logic [ENV_DIV_W-1:0] env_rate;
    logic                 pwm_out;
    logic [PWM_W-1:0]     mix_out;
    logic [NV-1:0]        active;

    always #5 clk = ~clk;

    poly_synth_pwm #(
        .NVOICES   (NV),
        .DIV_W     (DIV_W),
        .AMP_W     (AMP_W),
        .PWM_W     (PWM_W),
        .ENV_DIV_W (ENV_DIV_W)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_note_en  (note_en),
        .i_cfg_we   (cfg_we),
        .i_cfg_addr (cfg_addr),
        .i_cfg_data (cfg_data),
        .i_octave   (octave),
        .i_env_mode (env_mode),
        .i_env_rate (env_rate),
        .o_pwm_out  (pwm_out),
        .o_mix_out  (mix_out),
        .o_active   (active)
    );

    // Reference model state
    int m_hp   [NV];
    int m_cnt  [NV];
    int m_wave [NV];
    int m_amp  [NV];
    int m_pre;
    int m_mix;
    int m_latched;
    int m_pwm_cnt;
    int m_pwm;

    int n_vec = 0;
    int n_err = 0;

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            m_hp[v]   = 0;
            m_cnt[v]  = 0;
            m_wave[v] = 0;
            m_amp[v]  = 0;
        end
        m_pre     = 0;
        m_mix     = 0;
        m_latched = 0;
        m_pwm_cnt = 0;
        m_pwm     = 0;
    endtask

    // One clock edge of the behavioural model, using the inputs as they were
    // at the edge. Everything is computed from the pre-edge values.
    task automatic model_step();
        int tick;
        int sum;
        int ehp;
        if (rst_n !== 1'b1) begin
            model_reset();
            return;
        end
        tick = (m_pre >= int'(env_rate)) ? 1 : 0;
        sum  = 0;
        for (int v = 0; v < NV; v++) begin
            if (m_wave[v] != 0) sum += m_amp[v];
        end
        for (int v = 0; v < NV; v++) begin
            ehp = m_hp[v] / (1 << octave);
            if (ehp == 0) begin
                m_cnt[v]  = 0;
                m_wave[v] = 0;
            end else if (m_cnt[v] >= ehp - 1) begin
                m_cnt[v]  = 0;
                m_wave[v] = 1 - m_wave[v];
            end else begin
                m_cnt[v]  = m_cnt[v] + 1;
            end
            if (env_mode == 1'b0) begin
                m_amp[v] = note_en[v] ? AMP_MAX : 0;
            end else if (tick != 0) begin
                if (note_en[v]) m_amp[v] = (m_amp[v] + 1 > AMP_MAX) ? AMP_MAX : m_amp[v] + 1;
                else            m_amp[v] = (m_amp[v] - 1 < 0) ? 0 : m_amp[v] - 1;
            end
        end
        m_pwm = (m_pwm_cnt < m_latched) ? 1 : 0;
        if (m_pwm_cnt == PWM_MOD - 1) m_latched = m_mix;
        m_pwm_cnt = (m_pwm_cnt + 1) % PWM_MOD;
        m_mix = sum;
        if (cfg_we && int'(cfg_addr) < NV) m_hp[cfg_addr] = int'(cfg_data);
        m_pre = (tick != 0) ? 0 : m_pre + 1;
    endtask

    task automatic check_outputs(input string tag);
        logic [NV-1:0] exp_act;
        exp_act = '0;
        for (int v = 0; v < NV; v++) exp_act[v] = (m_amp[v] != 0);
        n_vec++;
        assert (mix_out === PWM_W'(m_mix)) else begin
            n_err++;
            $error("FAIL %s mix_out got %0d want %0d", tag, mix_out, m_mix);
        end
        n_vec++;
        assert (pwm_out === 1'(m_pwm)) else begin
            n_err++;
            $error("FAIL %s pwm_out got %0b want %0d", tag, pwm_out, m_pwm);
        end
        n_vec++;
        assert (active === exp_act) else begin
            n_err++;
            $error("FAIL %s active got %b want %b", tag, active, exp_act);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int want);
        n_vec++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s got %0d want %0d", tag, got, want);
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_outputs(tag);
    endtask

    task automatic cfg_write(input int addr, input int data, input string tag);
        cfg_we   = 1'b1;
        cfg_addr = ADDR_W'(addr);
        cfg_data = DIV_W'(data);
        step(tag);
        cfg_we   = 1'b0;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs("async_rst");
        step("in_rst");
        step("in_rst");
        rst_n = 1'b1;
    endtask

    // Counts pwm_out highs over one complete frame and compares with the
    // duty value the model latched for it. Optionally changes the gates in
    // the middle of the frame, which must not affect the frame in progress.
    task automatic run_frame(input string tag, input logic [NV-1:0] mid_gates);
        int waited;
        int highs;
        int want;
        waited = 0;
        while (m_pwm_cnt != 1 && waited < 300) begin
            step(tag);
            waited++;
        end
        if (m_pwm_cnt != 1) begin
            check_int({tag, "_timeout"}, waited, -1);
        end else begin
            want  = m_latched;
            highs = int'(pwm_out);
            for (int k = 1; k < PWM_MOD; k++) begin
                if (k == PWM_MOD / 2) note_en = mid_gates;
                step(tag);
                highs += int'(pwm_out);
            end
            check_int({tag, "_duty"}, highs, want);
        end
    endtask

    int peak;

    initial begin
        rst_n    = 1'b0;
        note_en  = '0;
        cfg_we   = 1'b0;
        cfg_addr = '0;
        cfg_data = '0;
        octave   = 2'd0;
        env_mode = 1'b0;
        env_rate = '0;
        model_reset();

        // Reset state and a short run before the mid-run reset
        step("reset");
        step("reset");
        rst_n = 1'b1;
        cfg_write(0, 4, "pre_cfg");
        note_en = 5'b00001;
        repeat (50) step("pre_run");

        // 1. Reset mid-note, release with all gates on and nothing programmed
        note_en = '1;
        pulse_reset();
        step("release");
        check_int("active_after_release", int'(active), 31);
        repeat (2000) step("idle");

        // 2. Basic tone on voice 0
        octave  = 2'd0;
        note_en = 5'b00001;
        cfg_write(0, 4, "tone_cfg");
        peak = 0;
        repeat (600) begin
            step("tone");
            if (int'(mix_out) > peak) peak = int'(mix_out);
        end
        check_int("tone_peak", peak, 15);
        run_frame("tone_frame", 5'b00001);

        // 3. Octave shift, half-period shrink and dropped writes
        octave  = 2'd2;
        note_en = 5'b00011;
        cfg_write(1, 16, "oct_cfg");
        repeat (200) step("octave");
        octave = 2'd0;
        cfg_write(1, 1000, "long_cfg");
        repeat (500) step("long");
        cfg_write(1, 2, "shrink_cfg");
        repeat (50) step("shrink");
        note_en = 5'b01010;
        cfg_write(3, 6, "v3_cfg");
        repeat (40) step("v3");
        cfg_write(7, 3, "addr7");
        cfg_write(5, 1, "addr5");
        cfg_write(6, 2, "addr6");
        repeat (100) step("addr_drop");

        // 4. Envelope ramp on voice 2
        env_mode = 1'b1;
        env_rate = 12'd3;
        note_en  = '0;
        pulse_reset();
        cfg_write(2, 4, "ramp_cfg");
        note_en = 5'b00100;
        repeat (70) step("ramp_up");
        peak = 0;
        repeat (16) begin
            step("ramp_top");
            if (int'(mix_out) > peak) peak = int'(mix_out);
        end
        check_int("ramp_peak", peak, 15);
        note_en = '0;
        repeat (24) step("ramp_down");
        note_en = 5'b00100;
        repeat (12) step("ramp_reverse");
        note_en = '0;
        repeat (70) step("ramp_release");
        check_int("release_done", int'(active), 0);

        // 5. Full polyphony, waves aligned by programming from reset
        env_mode = 1'b0;
        note_en  = '1;
        pulse_reset();
        for (int v = 0; v < NV; v++) cfg_write(v, 8, "poly_cfg");
        peak = 0;
        repeat (600) begin
            step("poly");
            if (int'(mix_out) > peak) peak = int'(mix_out);
        end
        check_int("poly_peak", peak, 75);

        // 6. Mid-frame mix change affects only later frames
        run_frame("frame_latch", 5'b00011);
        run_frame("frame_after", 5'b00011);

        // Randomised operation against the model
        repeat (3000) begin
            if ($urandom_range(0, 15) == 0) note_en  = NV'($urandom_range(0, 31));
            if ($urandom_range(0, 63) == 0) env_mode = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 63) == 0) env_rate = ENV_DIV_W'($urandom_range(0, 5));
            if ($urandom_range(0, 63) == 0) octave   = 2'($urandom_range(0, 3));
            cfg_we = ($urandom_range(0, 7) == 0);
            cfg_addr = ADDR_W'($urandom_range(0, 7));
            cfg_data = DIV_W'($urandom_range(0, 40));
            step("random");
        end
        cfg_we = 1'b0;
        run_frame("random_frame", 5'b10101);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
